// File: rtl/traffic_ctrl_param.sv
// Two-direction (A/B) traffic-light controller with configurable phase lengths, all-red
// clearance, pedestrian green-shortening and a night flash mode, timed by a tick strobe.
module traffic_ctrl_param #(
  parameter int CNT_W     = 8,
  parameter int T_GREEN   = 25,
  parameter int T_YELLOW  = 5,
  parameter int T_ALLRED  = 1,
  parameter int T_PED_MIN = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             ped_req,
  input  logic             night,
  output logic [2:0]       light_a,
  output logic [2:0]       light_b,
  output logic [CNT_W-1:0] remain,
  output logic             ped_pending
);

  typedef enum logic [2:0] {
    S_AG    = 3'd0,
    S_AY    = 3'd1,
    S_ACLR  = 3'd2,
    S_BG    = 3'd3,
    S_BY    = 3'd4,
    S_BCLR  = 3'd5,
    S_FLASH = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'((T_ALLRED > 0) ? T_ALLRED - 1 : 0);
  localparam logic [CNT_W-1:0] PED_CAP   = CNT_W'(T_PED_MIN - 1);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] GRN = 3'b010;
  localparam logic [2:0] YEL = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  state_t           state_q, state_d;
  state_t           next_green;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flash_q, flash_d;  // 0 = lamps lit, 1 = lamps dark
  logic             ped_q, ped_d;
  logic             go_yellow;
  logic             clr_end;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_AG;
      cnt_q   <= LD_GREEN;
      flash_q <= 1'b0;
      ped_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flash_q <= flash_d;
      ped_q   <= ped_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    flash_d    = flash_q;
    go_yellow  = 1'b0;
    clr_end    = 1'b0;
    next_green = S_AG;

    case (state_q)
      S_AG, S_BG: begin
        if (tick) begin
          if (night || cnt_q == '0) begin
            go_yellow = 1'b1;
            state_d   = (state_q == S_AG) ? S_AY : S_BY;
            cnt_d     = LD_YELLOW;
          end else if (ped_q && cnt_q > PED_CAP) begin
            cnt_d = PED_CAP;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_AY, S_BY: begin
        next_green = (state_q == S_AY) ? S_BG : S_AG;
        if (tick) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (T_ALLRED != 0) begin
            state_d = (state_q == S_AY) ? S_ACLR : S_BCLR;
            cnt_d   = LD_ALLRED;
          end else begin
            clr_end = 1'b1;
          end
        end
      end
      S_ACLR, S_BCLR: begin
        next_green = (state_q == S_ACLR) ? S_BG : S_AG;
        if (tick) begin
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          else             clr_end = 1'b1;
        end
      end
      S_FLASH: begin
        cnt_d = '0;
        if (tick) begin
          if (night) begin
            flash_d = ~flash_q;
          end else if (T_ALLRED != 0) begin
            state_d = S_BCLR;
            cnt_d   = LD_ALLRED;
          end else begin
            state_d = S_AG;
            cnt_d   = LD_GREEN;
          end
        end
      end
      default: begin
        state_d = S_AG;
        cnt_d   = LD_GREEN;
      end
    endcase

    // End of clearance: night diverts into flash instead of the next green
    if (clr_end) begin
      if (night) begin
        state_d = S_FLASH;
        cnt_d   = '0;
        flash_d = 1'b0;
      end else begin
        state_d = next_green;
        cnt_d   = LD_GREEN;
      end
    end

    // A request arriving on the serving cycle wins over the clear
    if (state_q == S_FLASH) ped_d = 1'b0;
    else                    ped_d = ped_req | (ped_q & ~go_yellow);
  end

  // Output decode from registered state only
  always_comb begin
    light_a     = RED;
    light_b     = RED;
    remain      = cnt_q;
    ped_pending = ped_q;
    case (state_q)
      S_AG:    light_a = GRN;
      S_AY:    light_a = YEL;
      S_BG:    light_b = GRN;
      S_BY:    light_b = YEL;
      S_FLASH: begin
        light_a = flash_q ? OFF : YEL;
        light_b = flash_q ? OFF : YEL;
        remain  = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Bench for traffic_ctrl_param: a default instance and a no-all-red instance, both compared every
// cycle against a phase-level model, plus hand-computed literal checks on the default instance.
module tb_traffic_ctrl_param;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] GRN = 3'b010;
  localparam logic [2:0] YEL = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  logic clk = 1'b0, rst_n = 1'b1, tick = 1'b1, ped_req = 1'b0, night = 1'b0;
  logic [2:0] la0, lb0, la1, lb1;
  logic [7:0] rem0, rem1;
  logic       pp0, pp1;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  traffic_ctrl_param #(.CNT_W(8), .T_GREEN(25), .T_YELLOW(5), .T_ALLRED(1), .T_PED_MIN(5)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .ped_req(ped_req), .night(night),
    .light_a(la0), .light_b(lb0), .remain(rem0), .ped_pending(pp0));

  traffic_ctrl_param #(.CNT_W(8), .T_GREEN(10), .T_YELLOW(3), .T_ALLRED(0), .T_PED_MIN(5)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .ped_req(ped_req), .night(night),
    .light_a(la1), .light_b(lb1), .remain(rem1), .ped_pending(pp1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- phase-level model ----------------
  typedef enum {K_GREEN, K_YELLOW, K_CLEAR, K_FLASH} kind_t;
  typedef struct {
    kind_t kind;
    bit    dir;    // 0 = A, 1 = B owns the phase
    int    left;   // ticks still to run in this phase, including the current one
    bit    lit;
    bit    pend;
  } mstate_t;
  typedef struct { int g; int y; int ar; int pm; } cfg_t;

  localparam cfg_t C0 = '{g: 25, y: 5, ar: 1, pm: 5};
  localparam cfg_t C1 = '{g: 10, y: 3, ar: 0, pm: 5};

  mstate_t m0, m1;

  function automatic mstate_t m_reset(input cfg_t c);
    mstate_t s;
    s.kind = K_GREEN; s.dir = 1'b0; s.left = c.g; s.lit = 1'b0; s.pend = 1'b0;
    return s;
  endfunction

  function automatic mstate_t after_clear(input mstate_t s, input cfg_t c, input bit nt);
    mstate_t n = s;
    if (nt) begin n.kind = K_FLASH; n.lit = 1'b1; n.left = 1; end
    else    begin n.kind = K_GREEN; n.dir = ~s.dir; n.left = c.g; end
    return n;
  endfunction

  function automatic mstate_t m_step(input mstate_t s, input cfg_t c, input bit tk, input bit pr, input bit nt);
    mstate_t n = s;
    bit served = 1'b0;
    if (tk) begin
      case (s.kind)
        K_GREEN: begin
          if (nt || s.left == 1) begin n.kind = K_YELLOW; n.left = c.y; served = 1'b1; end
          else if (s.pend && s.left > c.pm) n.left = c.pm;
          else n.left = s.left - 1;
        end
        K_YELLOW: begin
          if (s.left > 1)      n.left = s.left - 1;
          else if (c.ar > 0) begin n.kind = K_CLEAR; n.left = c.ar; end
          else                 n = after_clear(s, c, nt);
        end
        K_CLEAR: begin
          if (s.left > 1) n.left = s.left - 1;
          else            n = after_clear(s, c, nt);
        end
        K_FLASH: begin
          if (nt)            n.lit = ~s.lit;
          else if (c.ar > 0) begin n.kind = K_CLEAR; n.dir = 1'b1; n.left = c.ar; end
          else               begin n.kind = K_GREEN; n.dir = 1'b0; n.left = c.g; end
        end
      endcase
    end
    n.pend = (s.kind == K_FLASH) ? 1'b0 : (pr | (s.pend & ~served));
    return n;
  endfunction

  function automatic logic [2:0] m_light(input mstate_t s, input bit d);
    if (s.kind == K_FLASH) return s.lit ? YEL : OFF;
    if (s.dir != d)        return RED;
    case (s.kind)
      K_GREEN:  return GRN;
      K_YELLOW: return YEL;
      default:  return RED;
    endcase
  endfunction

  function automatic logic [7:0] m_remain(input mstate_t s);
    return (s.kind == K_FLASH) ? 8'd0 : 8'(s.left - 1);
  endfunction

  function automatic bit safe(input logic [2:0] a, input logic [2:0] b);
    return (a == RED) || (b == RED) || (a == b && (a == YEL || a == OFF));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= m_reset(C0);
      m1 <= m_reset(C1);
    end else begin
      m0 <= m_step(m0, C0, tick, ped_req, night);
      m1 <= m_step(m1, C1, tick, ped_req, night);
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    check("dut0 light_a", la0, m_light(m0, 1'b0));
    check("dut0 light_b", lb0, m_light(m0, 1'b1));
    check("dut0 remain", rem0, m_remain(m0));
    check("dut0 ped_pending", pp0, m0.pend);
    check("dut0 safety", safe(la0, lb0), 1);
    check("dut1 light_a", la1, m_light(m1, 1'b0));
    check("dut1 light_b", lb1, m_light(m1, 1'b1));
    check("dut1 remain", rem1, m_remain(m1));
    check("dut1 ped_pending", pp1, m1.pend);
    check("dut1 safety", safe(la1, lb1), 1);
  end

  // dut1 period and all-red monitor
  int cyc = 0, last_ag1 = -1, per1 = 0;
  bit allred1 = 1'b0;
  logic [2:0] prev_la1 = GRN;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    prev_la1 <= la1;
    if (!rst_n) begin
      last_ag1 <= -1;
      per1     <= 0;
    end else begin
      if (la1 == GRN && prev_la1 != GRN) begin
        if (last_ag1 >= 0) per1 <= cyc - last_ag1;
        last_ag1 <= cyc;
      end
      if (la1 == RED && lb1 == RED) allred1 <= 1'b1;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic count_phase(input logic [2:0] a, input logic [2:0] b, output int n);
    n = 0;
    while (la0 === a && lb0 === b && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_for(input string name, input logic [2:0] a, input logic [2:0] b, input logic [7:0] r);
    int n = 0;
    while (!(la0 === a && lb0 === b && rem0 === r) && n < 300) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s: timeout waiting for a=%b b=%b remain=%0d", name, a, b, r);
    end
  endtask

  initial begin
    int n, total;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset light_a", la0, GRN);
    check("reset light_b", lb0, RED);
    check("reset remain", rem0, 24);
    check("reset ped_pending", pp0, 0);
    rst_n = 1'b1;

    // 1: one full default cycle
    total = 0;
    count_phase(GRN, RED, n); check("t1 AG ticks", n, 25);   total += n;
    count_phase(YEL, RED, n); check("t1 AY ticks", n, 5);    total += n;
    count_phase(RED, RED, n); check("t1 ACLR ticks", n, 1);  total += n;
    count_phase(RED, GRN, n); check("t1 BG ticks", n, 25);   total += n;
    count_phase(RED, YEL, n); check("t1 BY ticks", n, 5);    total += n;
    count_phase(RED, RED, n); check("t1 BCLR ticks", n, 1);  total += n;
    check("t1 period", total, 62);
    check("t1 back to AG remain", rem0, 24);
    check("t6 dut1 period", per1, 26);
    check("t6 dut1 no all-red", allred1, 0);

    // 2: tick stall mid-BG
    wait_for("t2 wait BG12", RED, GRN, 12);
    tick = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t2 frozen remain", rem0, 12);
      check("t2 frozen light_b", lb0, GRN);
    end
    tick = 1'b1;
    @(negedge clk); check("t2 resume 11", rem0, 11);
    @(negedge clk); check("t2 resume 10", rem0, 10);

    // 3: pedestrian shortening, then a late request with no effect
    wait_for("t3 wait AG20", GRN, RED, 20);
    ped_req = 1'b1;
    @(negedge clk); ped_req = 1'b0;
    check("t3 ped latched", pp0, 1);
    check("t3 remain 19", rem0, 19);
    @(negedge clk); check("t3 shortened to 4", rem0, 4);
    count_phase(GRN, RED, n); check("t3 short green ticks", n, 5);
    check("t3 AY entry", la0, YEL);
    check("t3 ped cleared at AY", pp0, 0);

    wait_for("t3 wait AG3", GRN, RED, 3);
    ped_req = 1'b1;
    @(negedge clk); ped_req = 1'b0;
    check("t3b ped latched", pp0, 1);
    check("t3b remain 2", rem0, 2);
    @(negedge clk); check("t3b remain 1", rem0, 1);
    @(negedge clk); check("t3b remain 0", rem0, 0);
    @(negedge clk);
    check("t3b AY entry", la0, YEL);
    check("t3b ped cleared", pp0, 0);

    // 4: night mode from BG, flash, and exit
    wait_for("t4 wait BG15", RED, GRN, 15);
    night = 1'b1;
    @(negedge clk);
    check("t4 forced BY", lb0, YEL);
    check("t4 BY remain", rem0, 4);
    count_phase(RED, YEL, n); check("t4 BY ticks", n, 5);
    count_phase(RED, RED, n); check("t4 BCLR ticks", n, 1);
    check("t4 flash lit a", la0, YEL);
    check("t4 flash lit b", lb0, YEL);
    check("t4 flash remain", rem0, 0);
    @(negedge clk);
    check("t4 flash dark a", la0, OFF);
    check("t4 flash dark b", lb0, OFF);
    check("t4 flash ped", pp0, 0);
    @(negedge clk);
    check("t4 flash lit again", la0, YEL);
    night = 1'b0;
    @(negedge clk);
    check("t4 exit BCLR a", la0, RED);
    check("t4 exit BCLR b", lb0, RED);
    @(negedge clk);
    check("t4 exit AG", la0, GRN);
    check("t4 exit AG remain", rem0, 24);

    // 5: asynchronous reset between edges during BY
    wait_for("t5 wait BY3", RED, YEL, 3);
    ped_req = 1'b1;
    @(negedge clk); ped_req = 1'b0;
    check("t5 ped before reset", pp0, 1);
    check("t5 BY remain 2", rem0, 2);
    #2 rst_n = 1'b0;
    #1;
    check("t5 async light_a", la0, GRN);
    check("t5 async light_b", lb0, RED);
    check("t5 async remain", rem0, 24);
    check("t5 async ped", pp0, 0);
    check("t5 async dut1 remain", rem1, 9);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 6: let the no-all-red instance cycle again from reset
    repeat (60) @(negedge clk);
    check("t6 dut1 period after reset", per1, 26);
    check("t6 dut1 never all-red", allred1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
